// File: rtl/bnn_pkg.sv
// Shared helpers for the binary (+1/-1) convolution array:
// bit encoding, popcount and saturating partial-sum arithmetic.
package bnn_pkg;

  localparam int MAX_VEC_W = 256;

  // A bit b stands for the value 2*b-1
  localparam int BIN_SCALE = 2;

  localparam int PSUM_W_DEF = 14;
  localparam int PSUM_MAX = (1 <<< (PSUM_W_DEF - 1)) - 1;
  localparam int PSUM_MIN = -(1 <<< (PSUM_W_DEF - 1));

  function automatic int psum_hi(input int w);
    return (1 <<< (w - 1)) - 1;
  endfunction

  function automatic int psum_lo(input int w);
    return -(1 <<< (w - 1));
  endfunction

  function automatic int unsigned popcount(
    input logic [MAX_VEC_W-1:0] v
  );
    int unsigned n;
    n = 0;
    for (int i = 0; i < MAX_VEC_W; i++) begin
      n = n + {31'd0, v[i]};
    end
    return n;
  endfunction

  function automatic int sat_add(
    input int a,
    input int b,
    input int w
  );
    longint s;
    s = longint'(a) + longint'(b);
    if (s > longint'(psum_hi(w))) return psum_hi(w);
    if (s < longint'(psum_lo(w))) return psum_lo(w);
    return int'(s);
  endfunction

  function automatic logic sat_ovf(
    input int a,
    input int b,
    input int w
  );
    longint s;
    s = longint'(a) + longint'(b);
    return (s > longint'(psum_hi(w))) ||
           (s < longint'(psum_lo(w)));
  endfunction

endpackage

// File: rtl/pe_row_systolic_pe.sv
// One binary PE: stationary weight, XNOR-popcount contribution,
// saturating add onto the incoming psum, registered psum/valid/sat.
module pe_bin
  import bnn_pkg::*;
#(
  parameter int VEC_W  = 27,
  parameter int PSUM_W = 14
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     en_i,
  input  logic                     wr_i,
  input  logic [VEC_W-1:0]         weight_i,
  input  logic [VEC_W-1:0]         act_i,
  input  logic                     valid_i,
  input  logic                     sat_i,
  input  logic signed [PSUM_W-1:0] psum_i,
  output logic signed [PSUM_W-1:0] psum_o,
  output logic                     valid_o,
  output logic                     sat_o
);

  logic [VEC_W-1:0]         w_q;
  logic [VEC_W-1:0]         match;
  logic signed [PSUM_W-1:0] psum_q, psum_d;
  logic                     valid_q;
  logic                     sat_q, sat_d;
  int                       contrib;

  always_comb begin
    match   = ~(act_i ^ w_q);
    contrib = BIN_SCALE * int'(popcount(MAX_VEC_W'(match)))
              - VEC_W;
    psum_d  = PSUM_W'(sat_add(int'(psum_i), contrib, PSUM_W));
    sat_d   = sat_i | sat_ovf(int'(psum_i), contrib, PSUM_W);
  end

  // A weight write lands at the same edge the current beat
  // leaves, so that beat still sees the old weight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      w_q     <= '0;
      psum_q  <= '0;
      valid_q <= 1'b0;
      sat_q   <= 1'b0;
    end else if (en_i) begin
      if (wr_i) w_q <= weight_i;
      psum_q  <= psum_d;
      valid_q <= valid_i;
      sat_q   <= sat_d;
    end
  end

  assign psum_o  = psum_q;
  assign valid_o = valid_q;
  assign sat_o   = sat_q;

endmodule

// File: rtl/pe_row_systolic.sv
// Row of NUM_PE binary PEs: psum chains through the PEs while the
// activation slices are skewed to meet their beat at each PE.
module pe_row_systolic
  import bnn_pkg::*;
#(
  parameter int NUM_PE = 3,
  parameter int VEC_W  = 27,
  parameter int PSUM_W = 14,
  localparam int IDX_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1,
  localparam int ACT_W = NUM_PE * VEC_W
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     en_in,
  input  logic                     act_valid_in,
  input  logic [ACT_W-1:0]         activation_in,
  input  logic signed [PSUM_W-1:0] psum_in,
  input  logic                     weight_wr_in,
  input  logic [IDX_W-1:0]         weight_idx_in,
  input  logic [VEC_W-1:0]         weight_in,
  output logic [ACT_W-1:0]         activation_out,
  output logic                     act_valid_out,
  output logic signed [PSUM_W-1:0] psum_out,
  output logic                     psum_valid_out,
  output logic                     sat_out
);

  logic signed [PSUM_W-1:0] ps [NUM_PE+1];
  logic [NUM_PE:0]          vld;
  logic [NUM_PE:0]          st;

  logic [ACT_W-1:0]         act_q;
  logic                     act_valid_q;
  logic signed [PSUM_W-1:0] psum_q;
  logic                     psum_valid_q;
  logic                     sat_q;

  assign ps[0]  = psum_in;
  assign vld[0] = act_valid_in;
  assign st[0]  = 1'b0;

  for (genvar k = 0; k < NUM_PE; k++) begin : g_pe
    localparam int HI = (NUM_PE - k) * VEC_W - 1;
    logic [VEC_W-1:0] act_k;
    logic             wr_k;

    assign wr_k = weight_wr_in &&
                  (weight_idx_in == IDX_W'(k));

    if (k == 0) begin : g_direct
      assign act_k = activation_in[HI -: VEC_W];
    end else begin : g_skew
      logic [VEC_W-1:0] sk_q [k];

      always_ff @(posedge clk_in) begin
        if (rst_in) begin
          for (int j = 0; j < k; j++) sk_q[j] <= '0;
        end else if (en_in) begin
          sk_q[0] <= activation_in[HI -: VEC_W];
          for (int j = 1; j < k; j++) sk_q[j] <= sk_q[j-1];
        end
      end

      assign act_k = sk_q[k-1];
    end

    pe_bin #(
      .VEC_W  (VEC_W),
      .PSUM_W (PSUM_W)
    ) u_pe (
      .clk_i    (clk_in),
      .rst_i    (rst_in),
      .en_i     (en_in),
      .wr_i     (wr_k),
      .weight_i (weight_in),
      .act_i    (act_k),
      .valid_i  (vld[k]),
      .sat_i    (st[k]),
      .psum_i   (ps[k]),
      .psum_o   (ps[k+1]),
      .valid_o  (vld[k+1]),
      .sat_o    (st[k+1])
    );
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      act_q        <= '0;
      act_valid_q  <= 1'b0;
      psum_q       <= '0;
      psum_valid_q <= 1'b0;
      sat_q        <= 1'b0;
    end else if (en_in) begin
      act_q        <= activation_in;
      act_valid_q  <= act_valid_in;
      psum_q       <= ps[NUM_PE];
      psum_valid_q <= vld[NUM_PE];
      sat_q        <= st[NUM_PE];
    end
  end

  assign activation_out = act_q;
  assign act_valid_out  = act_valid_q;
  assign psum_out       = psum_q;
  assign psum_valid_out = psum_valid_q;
  assign sat_out        = sat_q;

endmodule

// File: tb/tb_pe_row_systolic.sv
// Directed bench for pe_row_systolic (NUM_PE=3, VEC_W=27,
// PSUM_W=14) with hand-computed expected psums.
module tb_pe_row_systolic;
  import bnn_pkg::*;

  localparam int NPE = 3;
  localparam int VW  = 27;
  localparam int PW  = 14;
  localparam int AW  = NPE * VW;

  logic                 clk;
  logic                 rst;
  logic                 en;
  logic                 act_valid;
  logic [AW-1:0]        act;
  logic signed [PW-1:0] psum;
  logic                 wr;
  logic [1:0]           widx;
  logic [VW-1:0]        wdata;
  logic [AW-1:0]        act_o;
  logic                 act_valid_o;
  logic signed [PW-1:0] psum_o;
  logic                 psum_valid_o;
  logic                 sat_o;

  int checks = 0;
  int errors = 0;

  logic [AW-1:0] ones;
  logic [AW-1:0] alt_all;
  logic [VW-1:0] alt;

  pe_row_systolic #(
    .NUM_PE (NPE),
    .VEC_W  (VW),
    .PSUM_W (PW)
  ) dut (
    .clk_in         (clk),
    .rst_in         (rst),
    .en_in          (en),
    .act_valid_in   (act_valid),
    .activation_in  (act),
    .psum_in        (psum),
    .weight_wr_in   (wr),
    .weight_idx_in  (widx),
    .weight_in      (wdata),
    .activation_out (act_o),
    .act_valid_out  (act_valid_o),
    .psum_out       (psum_o),
    .psum_valid_out (psum_valid_o),
    .sat_out        (sat_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string tag,
                       input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag,
                           input int exp_psum,
                           input logic exp_sat);
    check({tag, "_valid"}, 32'(psum_valid_o), 1);
    check({tag, "_psum"}, 32'(psum_o), exp_psum);
    check({tag, "_sat"}, 32'(sat_o), 32'(exp_sat));
  endtask

  task automatic beat(input logic [AW-1:0] a,
                      input int p);
    act_valid = 1'b1;
    act       = a;
    psum      = PW'(p);
    tick();
    act_valid = 1'b0;
    act       = '0;
    psum      = '0;
  endtask

  task automatic write_w(input logic [1:0] idx,
                         input logic [VW-1:0] w);
    wr    = 1'b1;
    widx  = idx;
    wdata = w;
    tick();
    wr    = 1'b0;
    wdata = '0;
  endtask

  initial begin
    ones = '1;
    for (int i = 0; i < VW; i++) alt[i] = (i % 2 == 0);
    alt_all = {alt, alt, alt};

    rst = 1'b1; en = 1'b1; act_valid = 1'b0; act = '0;
    psum = '0; wr = 1'b0; widx = '0; wdata = '0;
    ticks(2);
    rst = 1'b0;

    check("rst_psum", 32'(psum_o), 0);
    check("rst_psum_valid", 32'(psum_valid_o), 0);
    check("rst_sat", 32'(sat_o), 0);
    check("rst_act_valid", 32'(act_valid_o), 0);
    check("rst_act_zero", 32'(act_o == '0), 1);

    write_w(2'd0, '1);
    write_w(2'd1, '1);
    write_w(2'd2, '1);
    write_w(2'd3, '0);

    // all match, psum 5 -> 5 + 3*27
    beat(ones, 5);
    check("fwd_act_valid", 32'(act_valid_o), 1);
    check("fwd_act_ones", 32'(act_o == ones), 1);
    ticks(2);
    check("lat_early_valid", 32'(psum_valid_o), 0);
    tick();
    check_out("match5", 86, 1'b0);

    beat('0, 0);
    ticks(3);
    check_out("mismatch", -81, 1'b0);

    beat(alt_all, 0);
    ticks(3);
    check_out("alt", 3, 1'b0);

    act_valid = 1'b1; act = ones; psum = 14'sd0;
    tick();
    psum = 14'sd1;
    tick();
    psum = 14'sd2;
    tick();
    act_valid = 1'b0; act = '0; psum = '0;
    tick();
    check_out("b2b0", 81, 1'b0);
    tick();
    check_out("b2b1", 82, 1'b0);
    tick();
    check_out("b2b2", 83, 1'b0);
    tick();
    check("b2b_after_valid", 32'(psum_valid_o), 0);

    // stall two cycles; a beat offered while stalled is dropped
    beat(ones, 10);
    tick();
    en = 1'b0;
    act_valid = 1'b1; act = ones; psum = 14'sd1000;
    tick();
    tick();
    check("stall_hold_valid", 32'(psum_valid_o), 0);
    act_valid = 1'b0; act = '0; psum = '0;
    en = 1'b1;
    tick();
    check("stall_not_yet", 32'(psum_valid_o), 0);
    tick();
    check_out("stall", 91, 1'b0);
    tick();
    check("stall_dropped", 32'(psum_valid_o), 0);

    beat(ones, 8150);
    ticks(3);
    check_out("sat_pos", PSUM_MAX, 1'b1);
    check("sat_pos_hand", 32'(psum_o), 8191);

    beat('0, -8150);
    ticks(3);
    check_out("sat_neg", PSUM_MIN, 1'b1);
    check("sat_neg_hand", 32'(psum_o), -8192);

    beat(ones, 0);
    ticks(3);
    check_out("sat_clear", 81, 1'b0);

    // beat A at PE1 while PE1 weight is rewritten; beat B follows
    act_valid = 1'b1; act = ones; psum = '0;
    tick();
    wr = 1'b1; widx = 2'd1; wdata = '0;
    tick();
    wr = 1'b0; act_valid = 1'b0; act = '0;
    tick();
    tick();
    check_out("wr_old", 81, 1'b0);
    tick();
    check_out("wr_new", 27, 1'b0);

    write_w(2'd1, '1);
    act_valid = 1'b1; act = ones; psum = 14'sd7;
    tick();
    tick();
    act_valid = 1'b0; act = '0; psum = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_psum", 32'(psum_o), 0);
    check("mrst_sat", 32'(sat_o), 0);
    check("mrst_act_valid", 32'(act_valid_o), 0);
    check("mrst_act_zero", 32'(act_o == '0), 1);
    for (int i = 0; i < 4; i++) begin
      check("mrst_no_valid", 32'(psum_valid_o), 0);
      tick();
    end

    beat(ones, 0);
    ticks(3);
    check_out("mrst_wzero", -81, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
